// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: queues pushed bytes and launches
// one frame at a time via start/din/done, holding din steady for the whole frame.
module uart_tx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_done
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    // Pointer MSB is the lap flag: equal pointers = empty, same slot on different laps = full.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]) &&
                       (r_wptr[ADDR_W] != r_rptr[ADDR_W]);
    assign w_pop     = (r_state == IDLE) && !w_empty && !tx_busy;
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[ADDR_W-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (ADDR_W+1)'(1);
            if (push && !w_push_ok) r_overflow <= 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Completion is taken from tx_done only; tx_busy can be a single-cycle blip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rptr     <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_start <= 1'b0;
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rptr[ADDR_W-1:0]];
                        r_rptr     <= r_rptr + (ADDR_W+1)'(1);
                        r_tx_start <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    r_tx_start <= 1'b0;
                    if (tx_done) r_state <= IDLE;
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-cycle vector table plus hand sequences for
// frame pacing, overflow, full push+pop, pointer wrap and asynchronous reset.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       full, empty, overflow, tx_start;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] got [$];

    uart_tx_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [7:0] din;
        logic       busy;
        logic       done;
        logic       e_full;
        logic       e_empty;
        logic [4:0] e_count;
        logic       e_start;
        logic [7:0] e_data;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 0; tx_done = 0; tx_busy = 0;
        rst = 1;
        step();
        rst = 0;
    endtask

    // Runs ncyc cycles: pushes npush bytes (base+i) every gap cycles and answers each
    // tx_start with a one-cycle tx_done dly cycles later. Launched bytes go to got.
    task automatic drive_loop(input int ncyc, input int npush, input int gap,
                              input logic [7:0] base, input int dly, input bit chk_gap);
        int dl = -1;
        int last_done = -1;
        int pushed = 0;
        int unstable = 0;
        int badgap = 0;
        bit in_frame = 0;
        logic [7:0] cur = 8'h00;
        got.delete();
        for (int c = 0; c < ncyc; c++) begin
            push      = (pushed < npush) && (c % gap == 0);
            push_data = base + pushed[7:0];
            tx_done   = (c == dl);
            step();
            if (push) pushed++;
            if (tx_done) begin
                in_frame  = 0;
                last_done = c;
            end
            push = 0; tx_done = 0;
            if (tx_start) begin
                got.push_back(tx_data);
                if (chk_gap && last_done >= 0 && (c + 1) != last_done + 2) badgap++;
                cur = tx_data; in_frame = 1; dl = c + 1 + dly;
            end else if (in_frame && tx_data !== cur) begin
                unstable++;
            end
        end
        chk("frame_data_stable", unstable, 0);
        if (chk_gap) chk("start_gap_after_done", badgap, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        //            push din   busy done  full empty cnt start data  ovf
        vecs[0]  = '{1, 8'h41, 0, 0,   0, 0, 5'd1, 0, 8'h00, 0};
        vecs[1]  = '{0, 8'h00, 0, 0,   0, 1, 5'd0, 1, 8'h41, 0};
        vecs[2]  = '{0, 8'h00, 0, 0,   0, 1, 5'd0, 0, 8'h41, 0};
        vecs[3]  = '{1, 8'h55, 1, 0,   0, 0, 5'd1, 0, 8'h41, 0};
        vecs[4]  = '{0, 8'h00, 1, 1,   0, 0, 5'd1, 0, 8'h41, 0};
        vecs[5]  = '{0, 8'h00, 1, 0,   0, 0, 5'd1, 0, 8'h41, 0};
        vecs[6]  = '{0, 8'h00, 0, 0,   0, 1, 5'd0, 1, 8'h55, 0};
        vecs[7]  = '{0, 8'h00, 0, 1,   0, 1, 5'd0, 0, 8'h55, 0};
        vecs[8]  = '{0, 8'h00, 0, 0,   0, 1, 5'd0, 0, 8'h55, 0};
        vecs[9]  = '{0, 8'h00, 0, 1,   0, 1, 5'd0, 0, 8'h55, 0};
        vecs[10] = '{0, 8'h00, 0, 1,   0, 1, 5'd0, 0, 8'h55, 0};
        vecs[11] = '{1, 8'h66, 0, 0,   0, 0, 5'd1, 0, 8'h55, 0};
        vecs[12] = '{0, 8'h00, 0, 0,   0, 1, 5'd0, 1, 8'h66, 0};
        vecs[13] = '{0, 8'h00, 0, 0,   0, 1, 5'd0, 0, 8'h66, 0};

        // Reset state while rst is held
        #2;
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        step();
        rst = 0;
        for (int i = 0; i < 8; i++) step();

        // Cycle-by-cycle vectors: single push latency, busy gating, stray tx_done
        foreach (vecs[i]) begin
            push = vecs[i].push; push_data = vecs[i].din;
            tx_busy = vecs[i].busy; tx_done = vecs[i].done;
            step();
            push = 0; tx_done = 0;
            chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d_tx_start", i), tx_start, vecs[i].e_start);
            chk($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_data);
            chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ovf);
        end

        // Three back-to-back bytes, tx_done 100 cycles after each start
        do_reset();
        drive_loop(400, 3, 1, 8'h31, 100, 1);
        chk("three_frames_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("three_frames_byte%0d", i), got[i], 8'h31 + i);

        // Fill to 16 with transmitter busy, then push in the same cycle as the pop
        do_reset();
        tx_busy = 1;
        for (int i = 0; i < 16; i++) begin
            push = 1; push_data = 8'hC0 + 8'(i);
            step();
        end
        push = 0;
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_overflow", overflow, 0);
        chk("fill_tx_start", tx_start, 0);
        tx_busy = 0; push = 1; push_data = 8'hAA;
        step();
        push = 0;
        chk("pushpop_count", count, 16);
        chk("pushpop_full", full, 1);
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_tx_start", tx_start, 1);
        chk("pushpop_tx_data", tx_data, 8'hC0);
        // 17th byte while full and no pop: dropped, overflow sticks
        push = 1; push_data = 8'hEE;
        step();
        push = 0;
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 16);
        tx_done = 1;
        step();
        tx_done = 0;
        drive_loop(120, 0, 1, 8'h00, 3, 1);
        chk("drain_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk($sformatf("drain_byte%0d", i), got[i], (i < 15) ? 8'hC1 + i : 8'hAA);
        chk("drain_overflow_sticky", overflow, 1);
        chk("drain_empty", empty, 1);

        // Advance pointers, then 20 paced bytes crossing the wrap points
        drive_loop(13 * 8 + 20, 13, 8, 8'hB0, 3, 0);
        chk("filler_count", got.size(), 13);
        drive_loop(20 * 8 + 40, 20, 8, 8'h00, 3, 0);
        chk("wrap_count", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            chk($sformatf("wrap_byte%0d", i), got[i], i);
        chk("wrap_overflow_sticky", overflow, 1);

        // Reset during WAIT_DONE with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            push = 1; push_data = 8'h50 + 8'(i);
            step();
        end
        push = 0;
        chk("pre_rst_count", count, 5);
        #2 rst = 1;
        #1;
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_overflow", overflow, 0);
        step();
        rst = 0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_start) starts++;
        end
        chk("post_rst_no_start", starts, 0);
        push = 1; push_data = 8'h77;
        step();
        push = 0;
        step();
        chk("post_rst_new_start", tx_start, 1);
        chk("post_rst_new_data", tx_data, 8'h77);
        // Reset while tx_start is high drops it without waiting for a clock
        #2 rst = 1;
        #1;
        chk("launch_rst_tx_start", tx_start, 0);
        chk("launch_rst_tx_data", tx_data, 0);
        step();
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from the system side (watch/stopwatch display formatter, command echo) on a push strobe.
- Stores them in a circular FIFO.
- Feeds the transmitter one byte at a time using its start/din/done handshake.
- Holds din stable for the whole frame, because the transmitter samples din bit-by-bit during its DATA phase.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (default 16 entries).
- DATA_W, 8, byte width; must match the transmitter din width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- push  input  1  write strobe; one byte per cycle while high
- push_data  input  DATA_W  byte to enqueue
- full  output  1  FIFO holds 2**ADDR_W entries
- empty  output  1  FIFO holds 0 entries
- count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
- overflow  output  1  sticky; a push was dropped
- tx_start  output  1  one-cycle launch pulse to the transmitter start input
- tx_data  output  DATA_W  byte to the transmitter din input
- tx_busy  input  1  transmitter busy flag
- tx_done  input  1  transmitter one-cycle frame-complete pulse

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - Asynchronous active-high reset on rst.
- Reset values:
  - full=0, empty=1, count=0, overflow=0, tx_start=0, tx_data=0.
  - Read/write pointers = 0; FSM = IDLE.
  - Storage contents are don't-care.
- Pointers:
  - Read and write pointers are ADDR_W+1 bits; the MSB is the wrap flag.
  - empty when the pointers are fully equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally from 2**ADDR_W-1 to 0.
- Push:
  - Accepted when push=1 and either (not full) or (a pop occurs in the same cycle).
  - On accept: write to mem[wptr], then wptr+1.
  - Push when full with no same-cycle pop: byte is dropped, pointers are unchanged, overflow is set.
  - overflow stays set until rst.
- count: registered; +1 on accepted push only, -1 on pop only, unchanged when both or neither occur.
- Controller FSM has 3 states:
  - IDLE:
    - If not empty and tx_busy=0: pop the head (tx_data <= mem[rptr], rptr+1), go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH: tx_start=1 for exactly this one cycle; go to WAIT_DONE.
  - WAIT_DONE:
    - tx_start=0; tx_data held constant.
    - On tx_done=1, go to IDLE.
    - tx_busy is ignored in this state. Completion is decided by tx_done only, because busy may pulse for just one cycle.
- tx_data changes only on a pop in IDLE. It is held from pop until after tx_done, and stays at the last byte while idle.
- Latency:
  - Push into an empty FIFO at cycle N: empty deasserts at N+1; pop at N+1; tx_start high at N+2.
  - tx_done at cycle M with more data queued: back in IDLE at M+1, pop at M+1, next tx_start at M+2.
  - Minimum inter-frame gap is therefore 2 cycles after tx_done.
- Simultaneous events:
  - Push and pop in the same cycle on an empty FIFO cannot happen; a pop requires not empty at the start of the cycle.
  - Push and pop in the same cycle on a full FIFO: push accepted, count stays 2**ADDR_W.
- tx_done outside WAIT_DONE is ignored.
- Reset mid-frame:
  - All queued bytes are discarded; tx_start is forced 0 immediately (asynchronous).
  - The transmitter is reset by the same rst, so no handshake recovery is required.
- No timeout: a missing tx_done keeps the FSM in WAIT_DONE indefinitely while the FIFO continues accepting pushes up to full.

Test Plan:
- Reset, then single push 0x41 at cycle 10 -> empty=0 at 11; tx_start=1 only at cycle 12 with tx_data=0x41; count returns to 0 at 12.
- Push 3 bytes 0x31,0x32,0x33 back-to-back; model tx_done 100 cycles after each start -> exactly 3 tx_start pulses, in order; tx_data stable from each start until its tx_done; each next start 2 cycles after tx_done.
- With tx_done held 0, push 17 bytes -> full=1 and count=16 after 16 pushes; 17th dropped; overflow=1 and remains 1 through later traffic until rst.
- Full FIFO with FSM in IDLE (tx_busy released), push in the same cycle as the pop -> push accepted, count stays 16, full stays 1, no overflow.
- Push 20 bytes (0x00..0x13) paced to drain, crossing pointer wrap twice -> output sequence 0x00..0x13 exact, no loss or duplication.
- Assert rst during WAIT_DONE with 5 bytes queued -> tx_start=0, count=0, empty=1 immediately; after release, no tx_start until a new push.
